ula_video_out: RTL

//  Pixel output stage directly downstream of the ZX video controller.
//  - Takes its IRGB nibble or ULA+ palette byte, plus its sync and blank signals.
//  - Produces 8-bit-per-channel RGB with aligned syncs and a pixel clock enable
//    for the scandoubler/scaler.
//  - Handles Timex 512-px mode by doubling the pixel rate; switches rate only at a

---
 rtl/ula_video_pkg.sv | 22 ++
 rtl/ula_sync_pipe.sv | 28 ++
 rtl/ula_video_out.sv | 107 ++++++++++
 3 files changed

// File: rtl/ula_video_pkg.sv
// ula_video_pkg: level constants, ULA+ channel expansion and the sync/blank bundle
package ula_video_pkg;

    localparam logic [7:0] LVL_NORM   = 8'hD7;
    localparam logic [7:0] LVL_BRIGHT = 8'hFF;

    typedef struct packed {
        logic hs;
        logic vs;
        logic hbl;
        logic vbl;
    } sync_t;

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/ula_sync_pipe.sv
// ula_sync_pipe: two-deep enable-gated delay of syncs/blanks, matching the colour pipe
module ula_sync_pipe
    import ula_video_pkg::*;
(
    input  logic  clk_sys,
    input  logic  nRESET,
    input  logic  en_i,
    input  sync_t d_i,
    output sync_t q_o,
    output logic  s1_blank_o
);

    sync_t s1_q, s2_q;

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            s1_q <= '0;
            s2_q <= '0;
        end else if (en_i) begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o        = s2_q;
    assign s1_blank_o = s1_q.hbl | s1_q.vbl;

endmodule

// File: rtl/ula_video_out.sv
// ula_video_out: IRGB / ULA+ to 24-bit RGB with aligned syncs and pixel enable,
// switching between 7 and 14 MHz pixel rate only on a VSync rise.
module ula_video_out
    import ula_video_pkg::*;
#(
    parameter logic [7:0] NORM_LVL   = LVL_NORM,
    parameter logic [7:0] BRIGHT_LVL = LVL_BRIGHT
) (
    input  logic       clk_sys,
    input  logic       nRESET,
    input  logic       ce_7mp,
    input  logic       ce_7mn,
    input  logic       I,
    input  logic       R,
    input  logic       G,
    input  logic       B,
    input  logic       ulap_ena,
    input  logic       ulap_mono,
    input  logic [7:0] ulap_color,
    input  logic       mode512,
    input  logic       HSync,
    input  logic       VSync,
    input  logic       HBlank,
    input  logic       VBlank,
    output logic       ce_pix,
    output logic [7:0] R_o,
    output logic [7:0] G_o,
    output logic [7:0] B_o,
    output logic       HS_o,
    output logic       VS_o,
    output logic       HBl_o,
    output logic       VBl_o,
    output logic       mode512_act
);

    logic       pe, blank, mode_q, vs_prev_q, ce_pix_q;
    logic       ena_q, mono_q;
    logic [3:0] irgb_q;
    logic [7:0] col_q, lvl;
    logic [7:0] r_d, g_d, b_d, r_q, g_q, b_q;
    sync_t      sync_o;

    // Coincident ce phases collapse into one enable by the OR.
    assign pe = ce_7mn | (mode_q & ce_7mp);

    ula_sync_pipe u_sync (
        .clk_sys   (clk_sys),
        .nRESET    (nRESET),
        .en_i      (pe),
        .d_i       ('{hs: HSync, vs: VSync, hbl: HBlank, vbl: VBlank}),
        .q_o       (sync_o),
        .s1_blank_o(blank)
    );

    always_comb begin
        lvl = irgb_q[3] ? BRIGHT_LVL : NORM_LVL;
        r_d = blank ? 8'h00 : (ena_q & mono_q) ? col_q : ena_q ? expand3(col_q[4:2]) : irgb_q[2] ? lvl : 8'h00;
        g_d = blank ? 8'h00 : (ena_q & mono_q) ? col_q : ena_q ? expand3(col_q[7:5]) : irgb_q[1] ? lvl : 8'h00;
        b_d = blank ? 8'h00 : (ena_q & mono_q) ? col_q : ena_q ? expand2(col_q[1:0]) : irgb_q[0] ? lvl : 8'h00;
    end

    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            irgb_q <= '0;
            col_q  <= '0;
            ena_q  <= 1'b0;
            mono_q <= 1'b0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
        end else if (pe) begin
            irgb_q <= {I, R, G, B};
            col_q  <= ulap_color;
            ena_q  <= ulap_ena;
            mono_q <= ulap_mono;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
        end
    end

    // VSync edge is judged on ce_7mn samples only, so the rate cannot flip mid-period.
    always_ff @(posedge clk_sys or negedge nRESET) begin
        if (!nRESET) begin
            ce_pix_q  <= 1'b0;
            vs_prev_q <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            ce_pix_q <= pe;
            if (ce_7mn) begin
                vs_prev_q <= VSync;
                if (VSync && !vs_prev_q) mode_q <= mode512;
            end
        end
    end

    assign ce_pix      = ce_pix_q;
    assign R_o         = r_q;
    assign G_o         = g_q;
    assign B_o         = b_q;
    assign HS_o        = sync_o.hs;
    assign VS_o        = sync_o.vs;
    assign HBl_o       = sync_o.hbl;
    assign VBl_o       = sync_o.vbl;
    assign mode512_act = mode_q;

endmodule
